// File: rtl/joint_hist_pkg.sv
`default_nettype none
// joint_hist_pkg: FSM state type and bin-address width helper shared by the histogram engine.
package joint_hist_pkg;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DRAIN = 2'd2,
      ST_READ  = 2'd3
   } state_t;

   function automatic int bin_aw(input int ci_w, input int ni_w, input int rd_w);
      return ci_w + ni_w + rd_w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/joint_hist_ram.sv
`default_nettype none
// joint_hist_ram: 2^AW x DW simple dual-port bin store, one write port, one synchronous read port.
// A read of the address being written in the same cycle returns the old contents.
module joint_hist_ram
   import joint_hist_pkg::*;
#(
   parameter int AW = bin_aw(1, 4, 4),
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [0:(1<<AW)-1];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end

endmodule
`default_nettype wire

// File: rtl/joint_hist_engine.sv
`default_nettype none
// joint_hist_engine: joint histogram of {ci,ni,rd} sample codes with clear-on-read bin streaming.
// Define JOINT_HIST_SAT_EN for saturating counters and a live sat_o; otherwise counters wrap.
module joint_hist_engine
   import joint_hist_pkg::*;
#(
   parameter int CI_W  = 1,
   parameter int NI_W  = 4,
   parameter int RD_W  = 4,
   parameter int CNT_W = 16
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                sample_valid_i,
   input  logic [CI_W-1:0]                     ci_i,
   input  logic [NI_W-1:0]                     ni_i,
   input  logic [RD_W-1:0]                     rd_i,
   input  logic                                frame_done_i,
   input  logic                                bin_ready_i,
   output logic                                bin_valid_o,
   output logic [CNT_W-1:0]                    bin_o,
   output logic [bin_aw(CI_W,NI_W,RD_W)-1:0]   bin_idx_o,
   output logic                                bin_last_o,
   output logic                                busy_o,
   output logic                                finish_o,
   output logic                                sat_o
);

   localparam int AW = bin_aw(CI_W, NI_W, RD_W);
   localparam logic [AW-1:0] LAST_IDX = '1;

   state_t            state, state_nxt;
   logic [AW-1:0]     sample_addr;
   logic [AW-1:0]     clr_idx;
   logic [AW-1:0]     rd_idx, rd_idx_nxt;
   logic              rd_primed;
   logic              s1_valid;
   logic [AW-1:0]     s1_addr;
   logic              pw_valid;
   logic [AW-1:0]     pw_addr;
   logic [CNT_W-1:0]  pw_data;
   logic              ram_we;
   logic [AW-1:0]     ram_waddr, ram_raddr;
   logic [CNT_W-1:0]  ram_wdata, ram_rdata;
   logic [CNT_W-1:0]  cnt_base, cnt_inc;
   logic              sample_take, bin_valid, bin_accept, last_accept;
   logic              finish_q;

   assign sample_addr = {ci_i, ni_i, rd_i};
   assign sample_take = (state == ST_ACCUM) && sample_valid_i;
   assign bin_valid   = (state == ST_READ) && rd_primed;
   assign bin_accept  = bin_valid && bin_ready_i;
   assign last_accept = bin_accept && (rd_idx == LAST_IDX);

   always_ff @(posedge clk) begin
      if (rst) state <= ST_CLEAR;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_CLEAR: if (clr_idx == LAST_IDX) state_nxt = ST_ACCUM;
         ST_ACCUM: if (frame_done_i) state_nxt = ST_DRAIN;
         // No new samples enter in DRAIN, so the single in-flight write commits this cycle.
         ST_DRAIN: state_nxt = ST_READ;
         ST_READ:  if (last_accept) state_nxt = ST_ACCUM;
         default:  state_nxt = ST_CLEAR;
      endcase
   end

   always_comb begin
      ram_we     = 1'b0;
      ram_waddr  = s1_addr;
      ram_wdata  = cnt_inc;
      ram_raddr  = sample_addr;
      rd_idx_nxt = rd_idx;
      case (state)
         ST_CLEAR: begin
            ram_we    = 1'b1;
            ram_waddr = clr_idx;
            ram_wdata = '0;
         end
         ST_ACCUM, ST_DRAIN: ram_we = s1_valid;
         ST_READ: begin
            if (bin_accept) rd_idx_nxt = rd_idx + 1'b1;
            // Read port tracks the bin presented next cycle; it holds still while stalled.
            ram_we    = bin_accept;
            ram_waddr = rd_idx;
            ram_wdata = '0;
            ram_raddr = rd_idx_nxt;
         end
         default: ;
      endcase
   end

   // The RAM read for s1 cannot see the write issued in the same cycle; take it from pw instead.
   assign cnt_base = (pw_valid && (pw_addr == s1_addr)) ? pw_data : ram_rdata;

`ifdef JOINT_HIST_SAT_EN
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   logic cnt_sat;
   logic sat_q;

   assign cnt_sat = (cnt_base == CNT_MAX);
   assign cnt_inc = cnt_sat ? CNT_MAX : cnt_base + 1'b1;

   always_ff @(posedge clk) begin
      if (rst || last_accept)     sat_q <= 1'b0;
      else if (s1_valid && cnt_sat) sat_q <= 1'b1;
   end

   assign sat_o = sat_q;
`else
   assign cnt_inc = cnt_base + 1'b1;
   assign sat_o   = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid  <= 1'b0;
         pw_valid  <= 1'b0;
         clr_idx   <= '0;
         rd_idx    <= '0;
         rd_primed <= 1'b0;
         finish_q  <= 1'b0;
      end else begin
         s1_valid  <= sample_take;
         pw_valid  <= s1_valid;
         clr_idx   <= (state == ST_CLEAR) ? clr_idx + 1'b1 : '0;
         rd_idx    <= rd_idx_nxt;
         rd_primed <= (state == ST_READ);
         finish_q  <= last_accept;
      end
   end

   always_ff @(posedge clk) begin
      s1_addr <= sample_addr;
      pw_addr <= s1_addr;
      pw_data <= cnt_inc;
   end

   joint_hist_ram #(
      .AW (AW),
      .DW (CNT_W)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .raddr (ram_raddr),
      .rdata (ram_rdata)
   );

   assign bin_valid_o = bin_valid;
   assign bin_o       = bin_valid ? ram_rdata : '0;
   assign bin_idx_o   = rd_idx;
   assign bin_last_o  = bin_valid && (rd_idx == LAST_IDX);
   assign busy_o      = (state != ST_ACCUM);
   assign finish_o    = finish_q;

endmodule
`default_nettype wire

// File: tb/tb_joint_hist_engine.sv
`timescale 1ns/1ps
`default_nettype none
// tb_joint_hist_engine: directed checks of the histogram engine, a 16-bit build and a 4-bit build
// driven in lockstep from the same stimulus.
module tb_joint_hist_engine;

   logic        clk = 1'b0;
   logic        rst, sample_valid, frame_done, bin_ready;
   logic [0:0]  ci;
   logic [3:0]  ni, rd;
   logic        bin_valid, bin_last, busy, finish, sat;
   logic [15:0] bin;
   logic [8:0]  bin_idx;
   logic        bin_valid_s, bin_last_s, busy_s, finish_s, sat_s;
   logic [3:0]  bin_s;
   logic [8:0]  bin_idx_s;

   int passed = 0;
   int total  = 0;
   int got   [512];
   int got_s [512];
   int n_acc, first_lat, order_err, stable_err, last_err, fin_cnt;

`ifdef JOINT_HIST_SAT_EN
   localparam int SAT_EXP_CNT  = 15;
   localparam int SAT_EXP_FLAG = 1;
`else
   localparam int SAT_EXP_CNT  = 4;
   localparam int SAT_EXP_FLAG = 0;
`endif

   always #5 clk = ~clk;

   joint_hist_engine #(.CI_W(1), .NI_W(4), .RD_W(4), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .sample_valid_i(sample_valid),
      .ci_i(ci), .ni_i(ni), .rd_i(rd), .frame_done_i(frame_done), .bin_ready_i(bin_ready),
      .bin_valid_o(bin_valid), .bin_o(bin), .bin_idx_o(bin_idx), .bin_last_o(bin_last),
      .busy_o(busy), .finish_o(finish), .sat_o(sat)
   );

   joint_hist_engine #(.CI_W(1), .NI_W(4), .RD_W(4), .CNT_W(4)) dut_s (
      .clk(clk), .rst(rst), .sample_valid_i(sample_valid),
      .ci_i(ci), .ni_i(ni), .rd_i(rd), .frame_done_i(frame_done), .bin_ready_i(bin_ready),
      .bin_valid_o(bin_valid_s), .bin_o(bin_s), .bin_idx_o(bin_idx_s), .bin_last_o(bin_last_s),
      .busy_o(busy_s), .finish_o(finish_s), .sat_o(sat_s)
   );

   task automatic set_bin(input int idx);
      logic [8:0] a;
      a  = idx[8:0];
      ci = a[8];
      ni = a[7:4];
      rd = a[3:0];
   endtask

   task automatic wait_idle(output int cycles);
      cycles = 0;
      while (busy !== 1'b0 && cycles < 1000) begin
         @(posedge clk); #1;
         cycles++;
      end
   endtask

   // Pulses frame_done in the current slot and collects the streamed bins.
   task automatic readout(input bit rnd, input bit junk, input int stop_idx);
      bit          stalled;
      logic [15:0] pv_bin;
      logic [8:0]  pv_idx;
      logic        pv_last;
      int          cyc;
      n_acc = 0; first_lat = -1; order_err = 0; stable_err = 0; last_err = 0; fin_cnt = 0;
      stalled = 0; cyc = 0; pv_bin = '0; pv_idx = '0; pv_last = 1'b0;
      for (int i = 0; i < 512; i++) begin got[i] = -1; got_s[i] = -1; end
      frame_done = 1'b1;
      while (n_acc < 512 && cyc < 4000) begin
         @(posedge clk); #1;
         cyc++;
         frame_done = 1'b0;
         if (junk) begin sample_valid = 1'b1; set_bin(77); end
         else sample_valid = 1'b0;
         if (finish) fin_cnt++;
         if (stalled && (bin_valid !== 1'b1 || bin !== pv_bin || bin_idx !== pv_idx || bin_last !== pv_last))
            stable_err++;
         if (bin_valid && first_lat < 0) first_lat = cyc;
         if (bin_valid && bin_idx == stop_idx) begin
            rst = 1'b1;
            bin_ready = 1'b0;
            return;
         end
         bin_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         stalled = bin_valid && !bin_ready;
         pv_bin = bin; pv_idx = bin_idx; pv_last = bin_last;
         if (bin_valid && bin_ready) begin
            if (bin_idx != n_acc[8:0]) order_err++;
            if (bin_last != (n_acc == 511)) last_err++;
            got[bin_idx] = bin;
            if (bin_valid_s) got_s[bin_idx_s] = bin_s;
            n_acc++;
         end
      end
      bin_ready = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         sample_valid = 1'b0;
         if (finish) fin_cnt++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; sample_valid = 1'b0; frame_done = 1'b0; bin_ready = 1'b1; set_bin(0);
      repeat (2) begin @(posedge clk); #1; end
      total++; if (bin_valid !== 1'b0) $display("FAIL reset_bin_valid: got %b expected 0", bin_valid); else passed++;
      total++; if (bin !== 16'd0) $display("FAIL reset_bin: got %0d expected 0", bin); else passed++;
      total++; if (bin_idx !== 9'd0) $display("FAIL reset_bin_idx: got %0d expected 0", bin_idx); else passed++;
      total++; if (bin_last !== 1'b0) $display("FAIL reset_bin_last: got %b expected 0", bin_last); else passed++;
      total++; if (finish !== 1'b0) $display("FAIL reset_finish: got %b expected 0", finish); else passed++;
      total++; if (sat !== 1'b0 || sat_s !== 1'b0) $display("FAIL reset_sat: got %b/%b expected 0/0", sat, sat_s); else passed++;
      total++; if (busy !== 1'b1) $display("FAIL reset_busy: got %b expected 1", busy); else passed++;
      rst = 1'b0;
   endtask

   task automatic test_empty_frame();
      int w, nz;
      // Samples and frame_done during CLEAR must be ignored.
      sample_valid = 1'b1; set_bin(9); frame_done = 1'b1;
      repeat (10) begin @(posedge clk); #1; end
      sample_valid = 1'b0; frame_done = 1'b0;
      wait_idle(w);
      total++; if (10 + w != 512) $display("FAIL clear_length: got %0d cycles expected 512", 10 + w); else passed++;
      readout(1'b0, 1'b0, -1);
      nz = 0;
      for (int i = 0; i < 512; i++) if (got[i] != 0) nz++;
      total++; if (n_acc != 512) $display("FAIL empty_bin_count: got %0d expected 512", n_acc); else passed++;
      total++; if (nz != 0) $display("FAIL empty_nonzero_bins: got %0d expected 0", nz); else passed++;
      total++; if (order_err != 0) $display("FAIL empty_order: got %0d errors expected 0", order_err); else passed++;
      total++; if (last_err != 0) $display("FAIL empty_last_flag: got %0d errors expected 0", last_err); else passed++;
      total++; if (fin_cnt != 1) $display("FAIL empty_finish_pulses: got %0d expected 1", fin_cnt); else passed++;
      total++; if (!(first_lat >= 1 && first_lat <= 3)) $display("FAIL empty_first_valid_latency: got %0d expected 1..3", first_lat); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL empty_back_to_accum: got busy %b expected 0", busy); else passed++;
   endtask

   task automatic test_same_bin();
      int nz;
      sample_valid = 1'b1; ci = 1'b1; ni = 4'd3; rd = 4'd5;
      repeat (10) begin @(posedge clk); #1; end
      sample_valid = 1'b0;
      readout(1'b0, 1'b0, -1);
      nz = 0;
      for (int i = 0; i < 512; i++) if (i != 309 && got[i] != 0) nz++;
      total++; if (got[309] != 10) $display("FAIL same_bin_309: got %0d expected 10", got[309]); else passed++;
      total++; if (got_s[309] != 10) $display("FAIL same_bin_309_cnt4: got %0d expected 10", got_s[309]); else passed++;
      total++; if (nz != 0) $display("FAIL same_bin_others: got %0d nonzero expected 0", nz); else passed++;
      total++; if (!(first_lat >= 1 && first_lat <= 3)) $display("FAIL same_bin_first_valid_latency: got %0d expected 1..3", first_lat); else passed++;
      total++; if (fin_cnt != 1) $display("FAIL same_bin_finish_pulses: got %0d expected 1", fin_cnt); else passed++;
   endtask

   task automatic test_alternating();
      int nz;
      sample_valid = 1'b1;
      for (int i = 0; i < 99; i++) begin
         set_bin((i % 2 == 1) ? 511 : 0);
         @(posedge clk); #1;
      end
      set_bin(511);
      readout(1'b0, 1'b0, -1);
      nz = 0;
      for (int i = 1; i < 511; i++) if (got[i] != 0) nz++;
      total++; if (got[0] != 50) $display("FAIL alt_bin0: got %0d expected 50", got[0]); else passed++;
      total++; if (got[511] != 50) $display("FAIL alt_bin511: got %0d expected 50", got[511]); else passed++;
      total++; if (nz != 0) $display("FAIL alt_others: got %0d nonzero expected 0", nz); else passed++;
   endtask

   task automatic test_stall();
      int nz;
      int seq [8] = '{3, 3, 3, 7, 500, 500, 3, 128};
      sample_valid = 1'b1;
      foreach (seq[k]) begin
         set_bin(seq[k]);
         @(posedge clk); #1;
      end
      sample_valid = 1'b0;
      readout(1'b1, 1'b1, -1);
      nz = 0;
      for (int i = 0; i < 512; i++)
         if (i != 3 && i != 7 && i != 128 && i != 500 && got[i] != 0) nz++;
      total++; if (n_acc != 512) $display("FAIL stall_bin_count: got %0d expected 512", n_acc); else passed++;
      total++; if (stable_err != 0) $display("FAIL stall_stability: got %0d changes expected 0", stable_err); else passed++;
      total++; if (order_err != 0) $display("FAIL stall_order: got %0d errors expected 0", order_err); else passed++;
      total++; if (last_err != 0) $display("FAIL stall_last_flag: got %0d errors expected 0", last_err); else passed++;
      total++; if (got[3] != 4) $display("FAIL stall_bin3: got %0d expected 4", got[3]); else passed++;
      total++; if (got[7] != 1) $display("FAIL stall_bin7: got %0d expected 1", got[7]); else passed++;
      total++; if (got[500] != 2) $display("FAIL stall_bin500: got %0d expected 2", got[500]); else passed++;
      total++; if (got[128] != 1) $display("FAIL stall_bin128: got %0d expected 1", got[128]); else passed++;
      total++; if (nz != 0) $display("FAIL stall_others: got %0d nonzero expected 0", nz); else passed++;
      total++; if (fin_cnt != 1) $display("FAIL stall_finish_pulses: got %0d expected 1", fin_cnt); else passed++;
      readout(1'b1, 1'b0, -1);
      nz = 0;
      for (int i = 0; i < 512; i++) if (got[i] != 0) nz++;
      total++; if (n_acc != 512) $display("FAIL second_frame_bin_count: got %0d expected 512", n_acc); else passed++;
      total++; if (nz != 0) $display("FAIL second_frame_nonzero: got %0d expected 0", nz); else passed++;
   endtask

   task automatic test_saturation();
      sample_valid = 1'b1; set_bin(42);
      repeat (20) begin @(posedge clk); #1; end
      sample_valid = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      total++; if (sat_s !== 1'(SAT_EXP_FLAG)) $display("FAIL sat_flag_cnt4: got %b expected %0d", sat_s, SAT_EXP_FLAG); else passed++;
      total++; if (sat !== 1'b0) $display("FAIL sat_flag_cnt16: got %b expected 0", sat); else passed++;
      readout(1'b0, 1'b0, -1);
      total++; if (got_s[42] != SAT_EXP_CNT) $display("FAIL sat_bin42_cnt4: got %0d expected %0d", got_s[42], SAT_EXP_CNT); else passed++;
      total++; if (got[42] != 20) $display("FAIL sat_bin42_cnt16: got %0d expected 20", got[42]); else passed++;
      total++; if (sat_s !== 1'b0) $display("FAIL sat_clear_after_read: got %b expected 0", sat_s); else passed++;
   endtask

   task automatic test_reset_mid_read();
      int w, nz;
      sample_valid = 1'b1; set_bin(200);
      repeat (2) begin @(posedge clk); #1; end
      set_bin(5);
      @(posedge clk); #1;
      sample_valid = 1'b0;
      readout(1'b0, 1'b0, 100);
      @(posedge clk); #1;
      total++; if (bin_valid !== 1'b0) $display("FAIL midread_rst_valid: got %b expected 0", bin_valid); else passed++;
      total++; if (busy !== 1'b1) $display("FAIL midread_rst_busy: got %b expected 1", busy); else passed++;
      rst = 1'b0; bin_ready = 1'b1;
      wait_idle(w);
      total++; if (w != 512) $display("FAIL midread_clear_length: got %0d expected 512", w); else passed++;
      sample_valid = 1'b1; set_bin(5);
      repeat (3) begin @(posedge clk); #1; end
      sample_valid = 1'b0;
      readout(1'b0, 1'b0, -1);
      nz = 0;
      for (int i = 0; i < 512; i++) if (i != 5 && got[i] != 0) nz++;
      total++; if (got[5] != 3) $display("FAIL midread_fresh_bin5: got %0d expected 3", got[5]); else passed++;
      total++; if (got[200] != 0) $display("FAIL midread_fresh_bin200: got %0d expected 0", got[200]); else passed++;
      total++; if (nz != 0) $display("FAIL midread_fresh_others: got %0d nonzero expected 0", nz); else passed++;
      total++; if (fin_cnt != 1) $display("FAIL midread_fresh_finish: got %0d expected 1", fin_cnt); else passed++;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached with %0d/%0d checks passed", passed, total);
      $fatal(1, "time limit");
   end

   initial begin
      test_reset();
      test_empty_frame();
      test_same_bin();
      test_alternating();
      test_stall();
      test_saturation();
      test_reset_mid_read();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
